// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register for the EX-stage ALU: load-use hazard detection,
// bubble insertion, branch flush, MEM back-pressure, and saturating perf counters.
module id_ex_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_ID,
    input  logic [XLEN-1:0]   PC_ID,
    input  logic [XLEN-1:0]   busA_ID,
    input  logic [XLEN-1:0]   busB_ID,
    input  logic [XLEN-1:0]   imm_ID,
    input  logic [3:0]        ALUctr_ID,
    input  logic              ALUASrc_ID,
    input  logic [1:0]        ALUBSrc_ID,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic [REG_AW-1:0] rd_ID,
    input  logic              use_rs1_ID,
    input  logic              use_rs2_ID,
    input  logic              RegWr_ID,
    input  logic              MemRd_ID,
    input  logic              MemWr_ID,
    input  logic              MemtoReg_ID,
    input  logic              stall_ext,
    input  logic              flush_EX,
    output logic              valid_EX,
    output logic [XLEN-1:0]   PC_EX,
    output logic [XLEN-1:0]   busA_EX,
    output logic [XLEN-1:0]   busB_EX,
    output logic [XLEN-1:0]   imm_EX,
    output logic [3:0]        ALUctr_EX,
    output logic              ALUASrc_EX,
    output logic [1:0]        ALUBSrc_EX,
    output logic [REG_AW-1:0] rs1_EX,
    output logic [REG_AW-1:0] rs2_EX,
    output logic [REG_AW-1:0] rd_EX,
    output logic              RegWr_EX,
    output logic              MemRd_EX,
    output logic              MemWr_EX,
    output logic              MemtoReg_EX,
    output logic              stall_IF_ID,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   busa;
        logic [XLEN-1:0]   busb;
        logic [XLEN-1:0]   imm;
        logic [3:0]        aluctr;
        logic              alu_asrc;
        logic [1:0]        alu_bsrc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              regwr;
        logic              memrd;
        logic              memwr;
        logic              memtoreg;
    } ex_t;

    ex_t              ex_q, ex_d, id_s;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;

    assign id_s = '{valid: valid_ID, pc: PC_ID, busa: busA_ID, busb: busB_ID,
                    imm: imm_ID, aluctr: ALUctr_ID, alu_asrc: ALUASrc_ID,
                    alu_bsrc: ALUBSrc_ID, rs1: rs1_ID, rs2: rs2_ID, rd: rd_ID,
                    regwr: RegWr_ID, memrd: MemRd_ID, memwr: MemWr_ID,
                    memtoreg: MemtoReg_ID};

    // A load writing x0 produces nothing to wait for.
    assign load_use = valid_ID & ex_q.valid & ex_q.memrd & (ex_q.rd != '0) &
                      ((use_rs1_ID & (rs1_ID == ex_q.rd)) |
                       (use_rs2_ID & (rs2_ID == ex_q.rd)));

    assign stall_IF_ID = ~flush_EX & (stall_ext | load_use);

    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (flush_EX) begin
            ex_d = '0;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (stall_ext) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = '0;
            if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else begin
            ex_d = id_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign valid_EX    = ex_q.valid;
    assign PC_EX       = ex_q.pc;
    assign busA_EX     = ex_q.busa;
    assign busB_EX     = ex_q.busb;
    assign imm_EX      = ex_q.imm;
    assign ALUctr_EX   = ex_q.aluctr;
    assign ALUASrc_EX  = ex_q.alu_asrc;
    assign ALUBSrc_EX  = ex_q.alu_bsrc;
    assign rs1_EX      = ex_q.rs1;
    assign rs2_EX      = ex_q.rs2;
    assign rd_EX       = ex_q.rd;
    assign RegWr_EX    = ex_q.regwr;
    assign MemRd_EX    = ex_q.memrd;
    assign MemWr_EX    = ex_q.memwr;
    assign MemtoReg_EX = ex_q.memtoreg;
    assign bubble_cnt  = bubble_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: per-cycle compare against a behavioural model
// plus hand-computed literal expectations at key points.
module tb_id_ex_pipe;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    // Narrow counters keep the saturation run short.
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic valid_ID = 0, ALUASrc_ID = 0, use_rs1_ID = 0, use_rs2_ID = 0;
    logic RegWr_ID = 0, MemRd_ID = 0, MemWr_ID = 0, MemtoReg_ID = 0;
    logic stall_ext = 0, flush_EX = 0;
    logic [XLEN-1:0] PC_ID = 0, busA_ID = 0, busB_ID = 0, imm_ID = 0;
    logic [3:0] ALUctr_ID = 0;
    logic [1:0] ALUBSrc_ID = 0;
    logic [REG_AW-1:0] rs1_ID = 0, rs2_ID = 0, rd_ID = 0;

    logic valid_EX, ALUASrc_EX, RegWr_EX, MemRd_EX, MemWr_EX, MemtoReg_EX, stall_IF_ID;
    logic [XLEN-1:0] PC_EX, busA_EX, busB_EX, imm_EX;
    logic [3:0] ALUctr_EX;
    logic [1:0] ALUBSrc_EX;
    logic [REG_AW-1:0] rs1_EX, rs2_EX, rd_EX;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    id_ex_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID), .PC_ID(PC_ID),
        .busA_ID(busA_ID), .busB_ID(busB_ID), .imm_ID(imm_ID),
        .ALUctr_ID(ALUctr_ID), .ALUASrc_ID(ALUASrc_ID), .ALUBSrc_ID(ALUBSrc_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .RegWr_ID(RegWr_ID), .MemRd_ID(MemRd_ID), .MemWr_ID(MemWr_ID),
        .MemtoReg_ID(MemtoReg_ID), .stall_ext(stall_ext), .flush_EX(flush_EX),
        .valid_EX(valid_EX), .PC_EX(PC_EX), .busA_EX(busA_EX), .busB_EX(busB_EX),
        .imm_EX(imm_EX), .ALUctr_EX(ALUctr_EX), .ALUASrc_EX(ALUASrc_EX),
        .ALUBSrc_EX(ALUBSrc_EX), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
        .RegWr_EX(RegWr_EX), .MemRd_EX(MemRd_EX), .MemWr_EX(MemWr_EX),
        .MemtoReg_EX(MemtoReg_EX), .stall_IF_ID(stall_IF_ID),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: what EX must hold, as a list of named fields.
    typedef struct {
        bit v; bit [XLEN-1:0] pc, a, b, imm; bit [3:0] ctr; bit asrc; bit [1:0] bsrc;
        bit [REG_AW-1:0] rs1, rs2, rd; bit rw, mr, mw, m2r;
    } mex_t;
    mex_t m;
    int mb = 0, mf = 0;

    function automatic mex_t empty_ex();
        mex_t e;
        e = '{v: 0, pc: 0, a: 0, b: 0, imm: 0, ctr: 0, asrc: 0, bsrc: 0,
              rs1: 0, rs2: 0, rd: 0, rw: 0, mr: 0, mw: 0, m2r: 0};
        return e;
    endfunction

    function automatic bit m_hazard();
        if (!(valid_ID && m.v && m.mr && m.rd != 0)) return 0;
        return (use_rs1_ID && rs1_ID == m.rd) || (use_rs2_ID && rs2_ID == m.rd);
    endfunction

    initial m = empty_ex();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m = empty_ex(); mb = 0; mf = 0;
        end else if (flush_EX) begin
            m = empty_ex(); if (mf < CMAX) mf++;
        end else if (stall_ext) begin
            // EX contents stay put
        end else if (m_hazard()) begin
            m = empty_ex(); if (mb < CMAX) mb++;
        end else begin
            m = '{v: valid_ID, pc: PC_ID, a: busA_ID, b: busB_ID, imm: imm_ID,
                  ctr: ALUctr_ID, asrc: ALUASrc_ID, bsrc: ALUBSrc_ID, rs1: rs1_ID,
                  rs2: rs2_ID, rd: rd_ID, rw: RegWr_ID, mr: MemRd_ID, mw: MemWr_ID,
                  m2r: MemtoReg_ID};
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("valid_EX", valid_EX, m.v);     chk("PC_EX", PC_EX, m.pc);
        chk("busA_EX", busA_EX, m.a);       chk("busB_EX", busB_EX, m.b);
        chk("imm_EX", imm_EX, m.imm);       chk("ALUctr_EX", ALUctr_EX, m.ctr);
        chk("ALUASrc_EX", ALUASrc_EX, m.asrc); chk("ALUBSrc_EX", ALUBSrc_EX, m.bsrc);
        chk("rs1_EX", rs1_EX, m.rs1);       chk("rs2_EX", rs2_EX, m.rs2);
        chk("rd_EX", rd_EX, m.rd);          chk("RegWr_EX", RegWr_EX, m.rw);
        chk("MemRd_EX", MemRd_EX, m.mr);    chk("MemWr_EX", MemWr_EX, m.mw);
        chk("MemtoReg_EX", MemtoReg_EX, m.m2r);
        chk("bubble_cnt", bubble_cnt, mb);  chk("flush_cnt", flush_cnt, mf);
        chk("stall_IF_ID", stall_IF_ID, !flush_EX && (stall_ext || m_hazard()));
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic set_id(input bit v, input logic [XLEN-1:0] pc, input bit ld,
                          input logic [REG_AW-1:0] rd, input bit u1,
                          input logic [REG_AW-1:0] r1, input bit u2,
                          input logic [REG_AW-1:0] r2);
        valid_ID = v; PC_ID = pc; busA_ID = pc * 3; busB_ID = ~pc; imm_ID = pc + 4;
        ALUctr_ID = pc[5:2]; ALUASrc_ID = pc[2]; ALUBSrc_ID = pc[3:2];
        rd_ID = rd; use_rs1_ID = u1; rs1_ID = r1; use_rs2_ID = u2; rs2_ID = r2;
        RegWr_ID = 1; MemRd_ID = ld; MemtoReg_ID = ld; MemWr_ID = pc[4] & ~ld;
    endtask

    initial begin
        #1;
        chk("rst valid_EX", valid_EX, 0);    chk("rst PC_EX", PC_EX, 0);
        chk("rst bubble_cnt", bubble_cnt, 0); chk("rst stall", stall_IF_ID, 0);
        #11 rst_n = 1; chk_en = 1;

        // normal flow
        set_id(1, 32'h10, 0, 3, 1, 1, 1, 2);
        imm_ID = 32'h4; ALUctr_ID = 4'b0010; ALUBSrc_ID = 2'd2;
        tick();
        chk("nf PC_EX", PC_EX, 32'h10);   chk("nf imm_EX", imm_EX, 32'h4);
        chk("nf ALUBSrc", ALUBSrc_EX, 2); chk("nf valid", valid_EX, 1);
        chk("nf stall", stall_IF_ID, 0);

        // load-use on rs2
        set_id(1, 32'h14, 1, 5, 1, 1, 0, 0); tick();
        set_id(1, 32'h20, 0, 6, 1, 2, 1, 5); #1;
        chk("lu stall", stall_IF_ID, 1);
        tick();
        chk("lu valid", valid_EX, 0); chk("lu MemRd", MemRd_EX, 0);
        chk("lu bubble_cnt", bubble_cnt, 1); chk("lu stall after", stall_IF_ID, 0);
        tick();
        chk("lu capture PC", PC_EX, 32'h20); chk("lu capture valid", valid_EX, 1);

        // rd=0 load and unused-source match: no hazard
        set_id(1, 32'h24, 1, 0, 1, 1, 0, 0); tick();
        set_id(1, 32'h28, 0, 7, 1, 0, 1, 0); #1;
        chk("rd0 stall", stall_IF_ID, 0);
        tick(); chk("rd0 PC", PC_EX, 32'h28); chk("rd0 bubble_cnt", bubble_cnt, 1);
        set_id(1, 32'h2c, 1, 7, 0, 0, 0, 0); tick();
        set_id(1, 32'h30, 0, 8, 0, 7, 0, 0); #1;
        chk("unused rs1 stall", stall_IF_ID, 0);
        tick(); chk("unused rs1 PC", PC_EX, 32'h30);

        // flush coincident with load-use
        set_id(1, 32'h34, 1, 9, 0, 0, 0, 0); tick();
        set_id(1, 32'h38, 0, 1, 1, 9, 0, 0); flush_EX = 1; #1;
        chk("fl stall", stall_IF_ID, 0);
        tick(); flush_EX = 0;
        chk("fl valid", valid_EX, 0); chk("fl flush_cnt", flush_cnt, 1);
        chk("fl bubble_cnt", bubble_cnt, 1);

        // external stall for 3 cycles with ID changing underneath
        set_id(1, 32'h40, 0, 2, 1, 3, 1, 4); tick();
        stall_ext = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h44 + 4 * i, 0, 3, 0, 0, 0, 0); #1;
            chk("stx stall", stall_IF_ID, 1);
            tick(); chk("stx PC held", PC_EX, 32'h40);
        end
        set_id(1, 32'h50, 0, 4, 0, 0, 0, 0); stall_ext = 0; tick();
        chk("stx release PC", PC_EX, 32'h50);

        // external stall while a load-use is pending
        set_id(1, 32'h54, 1, 10, 0, 0, 0, 0); tick();
        set_id(1, 32'h58, 0, 11, 0, 0, 1, 10); stall_ext = 1;
        tick(); tick();
        chk("stx+lu held", PC_EX, 32'h54); chk("stx+lu bubble_cnt", bubble_cnt, 1);
        stall_ext = 0; tick();
        chk("stx+lu bubble", valid_EX, 0); chk("stx+lu cnt", bubble_cnt, 2);
        tick(); chk("stx+lu capture", PC_EX, 32'h58);

        // asynchronous reset in the middle of a stall
        stall_ext = 1; tick(); #1;
        rst_n = 0; #1;
        chk("arst valid", valid_EX, 0); chk("arst PC", PC_EX, 0);
        chk("arst rd", rd_EX, 0); chk("arst flush_cnt", flush_cnt, 0);
        chk("arst bubble_cnt", bubble_cnt, 0);
        stall_ext = 0; set_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("arst stall", stall_IF_ID, 0);
        @(negedge clk); #1 rst_n = 1;

        // bubble counter saturation: a self-dependent load alternates bubble/capture
        set_id(1, 32'h60, 1, 5, 1, 5, 0, 0);
        for (int i = 0; i < 2 * CMAX + 6; i++) tick();
        chk("sat bubble_cnt", bubble_cnt, CMAX);
        for (int i = 0; i < 2; i++) tick();
        chk("sat bubble_cnt hold", bubble_cnt, CMAX);

        // flush counter saturation
        flush_EX = 1;
        for (int i = 0; i < CMAX + 3; i++) tick();
        chk("sat flush_cnt", flush_cnt, CMAX);
        flush_EX = 0; set_id(0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
